mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage
Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, which is the maximum number of BUSY cycles allowed without dmem_ack.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 RegWriteM  in  1  register-write enable of the M-stage instruction.
REQ-005 ResultSrcM  in  2  result select; 2'b01 = load.
REQ-006 MemWriteM  in  1  store.
REQ-007 ALUResultM  in  32  effective address or ALU result.
REQ-008 WriteDataM  in  32  store data (rs2).
REQ-009 RdM  in  5  destination register.
REQ-010 PCPlus4M  in  32  link value.
REQ-011 Funct3M  in  3  access size and sign.
REQ-012 dmem_req  out  1  bus request, registered.
REQ-013 dmem_we  out  1  bus write, registered.
REQ-014 dmem_addr  out  32  word address, {ALUResultM[31:2],2'b00}, registered.
REQ-015 dmem_wdata  out  32  lane-replicated store data, registered.
REQ-016 dmem_be  out  4  byte enables, registered.
REQ-017 dmem_rdata  in  32  read word, valid with dmem_ack.
REQ-018 dmem_ack  in  1  transfer complete.
REQ-019 StallM  out  1  freezes PC/IF/ID/EX/EX-M registers.
REQ-020 FaultM  out  1  misaligned, unsupported-funct3 or timeout, one-cycle pulse.
REQ-021 RegWriteW, ResultSrcW[1:0], ALUResultW[31:0], ReadDataW[31:0], RdW[4:0], PCPlus4W[31:0]  out  MEM/WB register outputs.
Function
REQ-022 Access: acc = MemWriteM | (ResultSrcM==2'b01); non-access instructions pass to W in one cycle, StallM=0.
REQ-023 FSM states: IDLE, BUSY, DONE.
REQ-024 IDLE with acc and legal op: register bus outputs, set dmem_req=1, go BUSY, StallM=1.
REQ-025 BUSY: hold all bus outputs stable and StallM=1; on dmem_ack capture dmem_rdata, drop dmem_req next edge, go DONE.
REQ-026 BUSY timeout: counter reset on BUSY entry; if TIMEOUT cycles elapse without ack, drop dmem_req, go DONE with the error flag set.
REQ-027 DONE: StallM=0, W captures the instruction, FSM returns to IDLE; minimum access latency is 3 cycles (IDLE, BUSY with ack, DONE).
REQ-028 Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; ReadDataW is sign- or zero-extended from the lane selected by ALUResultM[1:0].
REQ-029 Legal stores: 000 sb (be=0001<<a[1:0], byte replicated x4), 001 sh (be=0011 or 1100, half replicated x2), 010 sw (be=1111).
REQ-030 Misaligned (half with a[0]=1; word with a[1:0]!=0) or unsupported funct3: no bus request, FaultM=1 combinationally that cycle, StallM=0, W captures with RegWriteW forced to 0.
REQ-031 Timeout fault: FaultM=1 during DONE; RegWriteW forced to 0; ReadDataW=0.
REQ-032 While StallM=1, W captures a bubble: RegWriteW=0, RdW=0, ResultSrcW=0, data fields 0.
REQ-033 Non-load instructions: ReadDataW=0; all other fields are copied from M.
REQ-034 dmem_ack outside BUSY SHALL be ignored.
Reset
REQ-035 On reset: FSM=IDLE, timeout counter=0, dmem_req/dmem_we=0, dmem_addr/dmem_wdata/dmem_be=0, and all W outputs=0, all asynchronously; StallM=0 and FaultM=0 while reset is held.
REQ-036 Reset during BUSY: the request is abandoned immediately; a late dmem_ack after reset deassertion SHALL be ignored.
Verification
REQ-037 lw at addr 0x100, ack in 2nd BUSY cycle, rdata 0xDEADBEEF -> StallM high 3 cycles, ReadDataW=0xDEADBEEF, RegWriteW=1.
REQ-038 lb at 0x103, rdata 0x80FF_0000 -> ReadDataW=0xFFFFFF80; same with lbu -> 0x00000080.
REQ-039 sh at 0x202, WriteDataM=0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, dmem_addr=0x200.
REQ-040 lw at 0x101 -> no dmem_req, FaultM pulse, RegWriteW=0, StallM never asserted.
REQ-041 lw with ack never asserted, TIMEOUT=15 -> dmem_req drops after 15 BUSY cycles, FaultM=1 in DONE, RegWriteW=0.
REQ-042 Reset asserted in 2nd BUSY cycle -> dmem_req=0 and StallM=0 immediately; ack after reset release causes no W write.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the pipelined core: issues one data-bus transaction per
// load/store, stalls the front of the pipeline while the bus is busy,
// extends load data, and owns the MEM/WB pipeline register.
module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    input  logic [2:0]  Funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        StallM,
    output logic        FaultM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt_p1;
    logic            err_p1;
    logic [31:0]     rdata_p1;

    logic            is_load, is_store, acc;
    logic            unsup, misal, illegal;
    logic            start_c, stall_c, fault_c, tmo_c;

    // Select and sign/zero-extend the addressed lane of a read word.
    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    // Replicate store data across every lane it may land in.
    function automatic logic [31:0] store_lanes(input logic [31:0] data,
                                                input logic [1:0]  size);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    // Byte-enable mask for the access size at the given byte offset.
    function automatic logic [3:0] byte_en(input logic [1:0] size,
                                           input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Decode the access kind and check size/alignment legality.
    always_comb begin
        is_store = MemWriteM;
        is_load  = ~MemWriteM & (ResultSrcM == 2'b01);
        acc      = is_store | is_load;
        if (is_store)
            unsup = Funct3M[2] | (Funct3M[1:0] == 2'b11);
        else
            unsup = (Funct3M[1:0] == 2'b11) | (Funct3M[2] & Funct3M[1]);
        misal    = ((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                   ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
        illegal  = acc & (unsup | misal);
    end

    // Next-state and stall/fault decisions for the bus handshake.
    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        stall_c   = 1'b0;
        fault_c   = 1'b0;
        tmo_c     = (cnt_p1 == CW'(TIMEOUT - 1));
        case (state)
            IDLE: begin
                if (acc && !illegal) begin
                    start_c   = 1'b1;
                    stall_c   = 1'b1;
                    state_nxt = BUSY;
                end else if (illegal) begin
                    fault_c   = 1'b1;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (dmem_ack || tmo_c)
                    state_nxt = DONE;
            end
            DONE: begin
                fault_c   = err_p1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign StallM = stall_c & ~reset;
    assign FaultM = fault_c & ~reset;

    // State register, timeout counter and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt_p1 <= '0;
            err_p1 <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_c) begin
                cnt_p1 <= '0;
                err_p1 <= 1'b0;
            end else if (state == BUSY) begin
                cnt_p1 <= cnt_p1 + 1'b1;
                if (dmem_ack)
                    err_p1 <= 1'b0;
                else if (tmo_c)
                    err_p1 <= 1'b1;
            end
        end
    end

    // Captured read word; only meaningful once an ack has been seen.
    always_ff @(posedge clk) begin
        if (state == BUSY && dmem_ack)
            rdata_p1 <= dmem_rdata;
    end

    // Bus request registers: loaded on access start, held while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
        end else if (start_c) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {ALUResultM[31:2], 2'b00};
            dmem_wdata <= store_lanes(WriteDataM, Funct3M[1:0]);
            dmem_be    <= byte_en(Funct3M[1:0], ALUResultM[1:0]);
        end else if (state == BUSY && (dmem_ack || tmo_c)) begin
            dmem_req   <= 1'b0;
        end
    end

    // MEM/WB register: bubble while stalled, faulting ops never write back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
        end else if (stall_c) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
        end else begin
            RegWriteW  <= RegWriteM & ~fault_c;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            if (state == DONE && is_load && !err_p1)
                ReadDataW <= load_ext(rdata_p1, Funct3M, ALUResultM[1:0]);
            else
                ReadDataW <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed instructions, scoreboarded MEM/WB results,
// plus direct checks of stall length, fault pulses and bus outputs.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic [2:0]  Funct3M;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        StallM, FaultM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } wrec_t;

    wrec_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        in_vld = 1'b0;
    logic        cap_pending = 1'b0;
    int          stall_n, fault_n, busy_n;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    mem_stage #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .Funct3M(Funct3M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .StallM(StallM), .FaultM(FaultM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: whenever an issued instruction was captured into W, compare.
    always @(negedge clk) begin
        wrec_t act, exp;
        if (cap_pending) begin
            act = {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got %h expected none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL wb_record: got %h expected %h", act, exp);
                end
            end
        end
        cap_pending = in_vld && !StallM && !reset;
    end

    task automatic set_nop();
        RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0; ALUResultM = 0;
        WriteDataM = 0; RdM = 0; PCPlus4M = 0; Funct3M = 0;
    endtask

    // Drive one instruction, answer the bus, and hold it until it leaves M.
    task automatic issue(input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc4,
                         input logic [2:0] f3, input int ack_at,
                         input logic [31:0] rdata, input logic exp_rw,
                         input logic [31:0] exp_rdat);
        bit done = 0;
        @(posedge clk); #1;
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; ALUResultM = alu;
        WriteDataM = wd; RdM = rd; PCPlus4M = pc4; Funct3M = f3;
        in_vld = 1'b1;
        exp_q.push_back({exp_rw, rs, alu, exp_rdat, rd, pc4});
        stall_n = 0; fault_n = 0; busy_n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (FaultM) fault_n++;
            dmem_ack = 1'b0;
            if (dmem_req) begin
                busy_n++;
                if (busy_n == 1) begin
                    cap_addr = dmem_addr; cap_wdata = dmem_wdata;
                    cap_be = dmem_be; cap_we = dmem_we;
                end
                if (busy_n == ack_at) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            if (!StallM) begin
                done = 1;
                break;
            end
            stall_n++;
        end
        if (!done) begin
            errors++;
            $display("FAIL stall_bound: got stuck expected release within 64");
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_vld = 1'b0;
        set_nop();
    endtask

    initial begin
        reset = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        set_nop();
        // An access presented during reset must not stall, fault or request.
        ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h100;
        #12;
        check("rst_stall", {31'b0, StallM}, 0);
        check("rst_fault", {31'b0, FaultM}, 0);
        check("rst_req", {31'b0, dmem_req}, 0);
        check("rst_w", {RegWriteW, ResultSrcW, RdW, 24'b0} | ALUResultW | ReadDataW | PCPlus4W, 0);
        set_nop();
        @(negedge clk); reset = 1'b0;

        // Plain ALU instruction passes straight through.
        issue(1, 2'b00, 0, 32'h12345678, 0, 5'd5, 32'h1004, 3'b000, -1, 0, 1, 0);
        check("alu_stall", stall_n, 0);

        // lw 0x100, ack in second BUSY cycle.
        issue(1, 2'b01, 0, 32'h100, 0, 5'd6, 32'h1008, 3'b010, 2, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        check("lw_stall", stall_n, 3);
        check("lw_addr", cap_addr, 32'h100);
        check("lw_we", {31'b0, cap_we}, 0);

        // lb / lbu at 0x103.
        issue(1, 2'b01, 0, 32'h103, 0, 5'd7, 32'h100C, 3'b000, 1, 32'h80FF0000, 1, 32'hFFFFFF80);
        check("lb_stall", stall_n, 2);
        issue(1, 2'b01, 0, 32'h103, 0, 5'd8, 32'h1010, 3'b100, 1, 32'h80FF0000, 1, 32'h00000080);

        // lh upper half (signed) and lhu lower half.
        issue(1, 2'b01, 0, 32'h102, 0, 5'd9, 32'h1014, 3'b001, 1, 32'h80011234, 1, 32'hFFFF8001);
        issue(1, 2'b01, 0, 32'h100, 0, 5'd10, 32'h1018, 3'b101, 3, 32'h8001F234, 1, 32'h0000F234);

        // sh at 0x202.
        issue(0, 2'b00, 1, 32'h202, 32'h1234ABCD, 5'd0, 32'h101C, 3'b001, 1, 0, 0, 0);
        check("sh_be", {28'b0, cap_be}, 32'hC);
        check("sh_wdata", cap_wdata, 32'hABCDABCD);
        check("sh_we", {31'b0, cap_we}, 1);
        check("sh_addr", cap_addr, 32'h200);

        // sb at 0x101.
        issue(0, 2'b00, 1, 32'h101, 32'h000000A5, 5'd0, 32'h1020, 3'b000, 1, 0, 0, 0);
        check("sb_be", {28'b0, cap_be}, 32'h2);
        check("sb_wdata", cap_wdata, 32'hA5A5A5A5);

        // Misaligned lw: no request, one fault pulse, no write-back.
        issue(1, 2'b01, 0, 32'h101, 0, 5'd11, 32'h1024, 3'b010, 1, 0, 0, 0);
        check("mis_stall", stall_n, 0);
        check("mis_fault", fault_n, 1);
        check("mis_busy", busy_n, 0);

        // Unsupported load funct3.
        issue(1, 2'b01, 0, 32'h100, 0, 5'd12, 32'h1028, 3'b011, 1, 0, 0, 0);
        check("unsup_fault", fault_n, 1);

        // lw with no ack: times out after 15 BUSY cycles.
        issue(1, 2'b01, 0, 32'h300, 0, 5'd13, 32'h102C, 3'b010, -1, 0, 0, 0);
        check("tmo_busy", busy_n, 15);
        check("tmo_stall", stall_n, 16);
        check("tmo_fault", fault_n, 1);
        idle();

        // Reset in second BUSY cycle abandons the request.
        @(posedge clk); #1;
        RegWriteM = 1; ResultSrcM = 2'b01; ALUResultM = 32'h400; RdM = 5'd14; Funct3M = 3'b010;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_req", {31'b0, dmem_req}, 1);
        reset = 1'b1;
        set_nop();
        #1;
        check("arst_req", {31'b0, dmem_req}, 0);
        check("arst_stall", {31'b0, StallM}, 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk); dmem_ack = 1'b0;
        check("late_ack_rw", {31'b0, RegWriteW}, 0);
        check("late_ack_rd", ReadDataW, 0);
        check("late_ack_req", {31'b0, dmem_req}, 0);

        // Pipeline resumes normally.
        issue(1, 2'b00, 0, 32'hCAFEF00D, 0, 5'd15, 32'h2000, 3'b000, -1, 0, 1, 0);
        idle();
        @(negedge clk);
        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
